hot_query_sched: RTL
====================

# hot_query_sched

Epoch controller for the hot-page tracker in the AFU. It counts accepted read accesses entering the tracker and times each epoch. When an epoch closes, it fires the tracker's query handshake and drains the resulting migration-address stream to the downstream migration queue. It replaces bench/software-driven query pacing with a hardware scheduler sitting between the AXI read-snoop path, the tracker top, and the migration address queue.

## Interface
Parameters:
- ADDR_SIZE, 33: migration address width
- EPOCH_ACCESSES, 2000: accesses per epoch (≥1)
- EPOCH_TIMEOUT, 1000000: max cycles per epoch before forced query (≥1)
- NUM_ENTRY, 25: max migration addresses per query (tracker CAM depth)
- QUIET_CYCLES, 64: idle cycles ending a drain early (≥1)
- EPOCH_ID_W, 16: epoch counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  allows automatic/software triggers
- access_valid  in  1  one pulse per accepted AR handshake (arvalid & arready)
- sw_query_req  in  1  single-cycle software query request
- query_en  out  1  query request to tracker
- query_ready  in  1  tracker accepts query
- mig_addr_en  in  1  tracker migration address valid
- mig_addr  in  ADDR_SIZE  tracker migration address
- mig_addr_ready  out  1  ready back to tracker
- out_valid  out  1  migration address to queue
- out_addr  out  ADDR_SIZE  migration address to queue
- out_ready  in  1  queue ready
- busy  out  1  state ≠ COUNT
- epoch_id  out  EPOCH_ID_W  completed-epoch count
- last_mig_cnt  out  $clog2(NUM_ENTRY+1)  addresses forwarded in last epoch

## Operation
- FSM states: COUNT, REQ, DRAIN, DONE.
- COUNT:
  - access_cnt (saturating at EPOCH_ACCESSES) increments on access_valid.
  - timer (saturating at EPOCH_TIMEOUT) increments each cycle.
  - sw_query_req sets sw_pend.
  - Trigger = enable & (access_cnt == EPOCH_ACCESSES | sw_pend | (timer == EPOCH_TIMEOUT & access_cnt != 0)). On trigger -> REQ.
- Entering REQ:
  - access_cnt <= access_valid ? 1 : 0. Accesses in REQ/DRAIN/DONE count toward the next epoch.
  - timer <= 0, sw_pend <= 0.
- REQ: query_en = 1. Drops the cycle after query_ready is sampled high -> DRAIN.
- DRAIN:
  - Passthrough, combinational: out_valid = mig_addr_en, out_addr = mig_addr, mig_addr_ready = out_ready.
  - Transfer = mig_addr_en & out_ready; each transfer increments mig_cnt.
  - quiet counter clears on mig_addr_en and increments otherwise.
  - -> DONE when mig_cnt reaches NUM_ENTRY or quiet reaches QUIET_CYCLES.
- DONE (1 cycle): last_mig_cnt <= mig_cnt, mig_cnt <= 0, epoch_id += 1 (wraps modulo 2^EPOCH_ID_W) -> COUNT.
- Outside DRAIN: mig_addr_ready = 0, out_valid = 0.
- enable low:
  - Blocks only new triggers; an in-flight REQ/DRAIN completes.
  - sw_pend is held until enable returns.
  - Counters keep running.
- sw_query_req during REQ/DRAIN/DONE is latched and serviced on return to COUNT.
- Timeout with access_cnt == 0 does not trigger; timer holds saturated.

## Timing
- Reset, asynchronous:
  - state = COUNT.
  - query_en, out_valid, mig_addr_ready, busy = 0.
  - epoch_id, last_mig_cnt, access_cnt, timer, mig_cnt, quiet, sw_pend = 0.
- Trigger latency: the access_valid making access_cnt == EPOCH_ACCESSES is registered at edge N; query_en rises at edge N+1.
- Handshake rules:
  - query_en stays high until query_ready; it never deasserts early.
  - If query_ready is already high when query_en rises, query_en is high exactly 1 cycle.
- DRAIN forwarding has zero latency. Tracker back-pressure equals queue back-pressure.
- Minimum epoch overhead: REQ 1 + DRAIN ≥1 + DONE 1 = 3 cycles.
- Reset mid-DRAIN aborts the drain; the partial epoch is not counted.

## Structure
- hot_tracker_pkg holds the state enum typedef t_qsched_state and the default constants (EPOCH_ACCESSES, EPOCH_TIMEOUT, QUIET_CYCLES).
- Single module, no sub-modules. A saturating-counter helper is inlined.

## Test plan
- 2000 access_valid pulses, enable=1, query_ready tied high:
  - query_en high exactly 1 cycle, 1 cycle after the 2000th pulse.
  - 25 addresses forwarded; last_mig_cnt = 25; epoch_id = 1.
- query_ready delayed 7 cycles: query_en held 7 cycles; access_valid during REQ yields access_cnt = 1 at return to COUNT.
- Tracker emits 10 addresses then idles: DONE after 64 quiet cycles; last_mig_cnt = 10.
- out_ready toggled 1/0 during drain: mig_addr_ready mirrors out_ready; every address is forwarded once and in order; no drops.
- 5 accesses, then idle for EPOCH_TIMEOUT (param 100): forced query. With zero accesses, no query occurs.
- sw_query_req with enable=0: no query. Raise enable: query_en next cycle. Assert rst_n low mid-DRAIN: all outputs 0, epoch_id 0.

Source files
------------

// File: rtl/hot_tracker_pkg.sv
// Shared types and default constants for the hot-page tracker epoch scheduler.
//   t_qsched_state : scheduler FSM state encoding
//   DEF_*          : default epoch sizing used as parameter defaults
package hot_tracker_pkg;

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_qsched_state;

    localparam int unsigned DEF_EPOCH_ACCESSES = 2000;
    localparam int unsigned DEF_EPOCH_TIMEOUT  = 1000000;
    localparam int unsigned DEF_QUIET_CYCLES   = 64;

endpackage

// File: rtl/hot_query_sched.sv
// hot_query_sched: epoch controller for the hot-page tracker.
// Counts accepted read accesses and epoch cycles; when an epoch closes it
// issues the tracker query handshake, then forwards the tracker's
// migration-address stream to the migration queue.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                allows new epoch triggers
//   access_valid          one pulse per accepted AR handshake
//   sw_query_req          single-cycle software query request
//   query_en/query_ready  query handshake to the tracker
//   mig_addr_en/mig_addr/mig_addr_ready  address stream from the tracker
//   out_valid/out_addr/out_ready         address stream to the queue
//   busy                  scheduler is not in COUNT
//   epoch_id              completed-epoch count (wraps)
//   last_mig_cnt          addresses forwarded in the last epoch
//
// state | meaning
// COUNT | counting accesses/cycles, waiting for a trigger
// REQ   | query_en held until the tracker accepts
// DRAIN | passthrough of migration addresses to the queue
// DONE  | one cycle: publish count, bump epoch_id
module hot_query_sched
    import hot_tracker_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = 33,
    parameter int unsigned EPOCH_ACCESSES = DEF_EPOCH_ACCESSES,
    parameter int unsigned EPOCH_TIMEOUT  = DEF_EPOCH_TIMEOUT,
    parameter int unsigned NUM_ENTRY      = 25,
    parameter int unsigned QUIET_CYCLES   = DEF_QUIET_CYCLES,
    parameter int unsigned EPOCH_ID_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               access_valid,
    input  logic                               sw_query_req,
    output logic                               query_en,
    input  logic                               query_ready,
    input  logic                               mig_addr_en,
    input  logic [ADDR_SIZE-1:0]               mig_addr,
    output logic                               mig_addr_ready,
    output logic                               out_valid,
    output logic [ADDR_SIZE-1:0]               out_addr,
    input  logic                               out_ready,
    output logic                               busy,
    output logic [EPOCH_ID_W-1:0]              epoch_id,
    output logic [$clog2(NUM_ENTRY+1)-1:0]     last_mig_cnt
);

    localparam int unsigned ACC_W   = $clog2(EPOCH_ACCESSES + 1);
    localparam int unsigned TMR_W   = $clog2(EPOCH_TIMEOUT + 1);
    localparam int unsigned QUIET_W = $clog2(QUIET_CYCLES + 1);
    localparam int unsigned MIG_W   = $clog2(NUM_ENTRY + 1);

    localparam logic [ACC_W-1:0]   ACC_MAX   = ACC_W'(EPOCH_ACCESSES);
    localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(EPOCH_TIMEOUT);
    localparam logic [QUIET_W-1:0] QUIET_MAX = QUIET_W'(QUIET_CYCLES);
    localparam logic [MIG_W-1:0]   MIG_MAX   = MIG_W'(NUM_ENTRY);

    t_qsched_state           state_q, state_d;
    logic [ACC_W-1:0]        access_cnt_q, access_cnt_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [QUIET_W-1:0]      quiet_q, quiet_d;
    logic [MIG_W-1:0]        mig_cnt_q, mig_cnt_d;
    logic [MIG_W-1:0]        last_mig_cnt_q, last_mig_cnt_d;
    logic [EPOCH_ID_W-1:0]   epoch_id_q, epoch_id_d;
    logic                    sw_pend_q, sw_pend_d;
    logic                    trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_COUNT;
            access_cnt_q   <= '0;
            timer_q        <= '0;
            quiet_q        <= '0;
            mig_cnt_q      <= '0;
            last_mig_cnt_q <= '0;
            epoch_id_q     <= '0;
            sw_pend_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            access_cnt_q   <= access_cnt_d;
            timer_q        <= timer_d;
            quiet_q        <= quiet_d;
            mig_cnt_q      <= mig_cnt_d;
            last_mig_cnt_q <= last_mig_cnt_d;
            epoch_id_q     <= epoch_id_d;
            sw_pend_q      <= sw_pend_d;
        end
    end

    // A timeout only closes an epoch that actually saw traffic.
    assign trigger = enable & ((access_cnt_q == ACC_MAX) | sw_pend_q |
                               ((timer_q == TMR_MAX) & (access_cnt_q != '0)));

    always_comb begin
        state_d        = state_q;
        access_cnt_d   = access_cnt_q;
        timer_d        = timer_q;
        quiet_d        = quiet_q;
        mig_cnt_d      = mig_cnt_q;
        last_mig_cnt_d = last_mig_cnt_q;
        epoch_id_d     = epoch_id_q;
        sw_pend_d      = sw_pend_q | sw_query_req;
        query_en       = 1'b0;
        out_valid      = 1'b0;
        mig_addr_ready = 1'b0;

        // Counters run in every state so accesses arriving while a query is
        // in flight are credited to the next epoch.
        if (access_valid && (access_cnt_q != ACC_MAX)) begin
            access_cnt_d = access_cnt_q + 1'b1;
        end
        if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_COUNT: begin
                if (trigger) begin
                    state_d      = ST_REQ;
                    access_cnt_d = ACC_W'(access_valid);
                    timer_d      = '0;
                    sw_pend_d    = 1'b0;
                end
            end
            ST_REQ: begin
                query_en = 1'b1;
                if (query_ready) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid      = mig_addr_en;
                mig_addr_ready = out_ready;
                if (mig_addr_en && out_ready && (mig_cnt_q != MIG_MAX)) begin
                    mig_cnt_d = mig_cnt_q + 1'b1;
                end
                if (mig_addr_en) begin
                    quiet_d = '0;
                end else if (quiet_q != QUIET_MAX) begin
                    quiet_d = quiet_q + 1'b1;
                end
                // Decide on the updated counts so no transfer beyond the
                // CAM depth is ever accepted.
                if ((mig_cnt_d == MIG_MAX) || (quiet_d == QUIET_MAX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_mig_cnt_d = mig_cnt_q;
                mig_cnt_d      = '0;
                quiet_d        = '0;
                epoch_id_d     = epoch_id_q + 1'b1;
                state_d        = ST_COUNT;
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    assign out_addr     = mig_addr;
    assign busy         = (state_q != ST_COUNT);
    assign epoch_id     = epoch_id_q;
    assign last_mig_cnt = last_mig_cnt_q;

endmodule
